// File: rtl/conv_window_scheduler.sv
// Walks a KERNEL x KERNEL window over a MAP_X x MAP_Y feature map and presents
// every tap's (x,y) coordinate per window over a valid/ready handshake.
module conv_window_scheduler #(
  parameter int KERNEL     = 5,
  parameter int ADDR_WIDTH = 16,
  parameter int MAP_X      = 25,
  parameter int MAP_Y      = 30,
  parameter int STRIDE     = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  win_valid,
  input  logic                                  win_ready,
  output logic                                  win_last,
  output logic [ADDR_WIDTH-1:0]                 win_idx,
  output logic [KERNEL*KERNEL*ADDR_WIDTH-1:0]   win_x,
  output logic [KERNEL*KERNEL*ADDR_WIDTH-1:0]   win_y
);

  localparam int     PORT_NUM = KERNEL * KERNEL;
  localparam int     S_SAFE   = (STRIDE < 1) ? 1 : STRIDE;
  localparam int     NX       = (MAP_X - KERNEL) / S_SAFE + 1;
  localparam int     NY       = (MAP_Y - KERNEL) / S_SAFE + 1;
  localparam int     OX_MAX   = (NX - 1) * S_SAFE;
  localparam int     OY_MAX   = (NY - 1) * S_SAFE;
  localparam longint NWIN     = longint'(NX) * longint'(NY);

  localparam bit LEGAL = (KERNEL <= MAP_X) && (KERNEL <= MAP_Y) && (STRIDE >= 1) &&
                         ((longint'(MAP_X) >> ADDR_WIDTH) == 0) &&
                         ((longint'(MAP_Y) >> ADDR_WIDTH) == 0) &&
                         ((NWIN >> ADDR_WIDTH) == 0);

  if (!LEGAL) begin : g_illegal
    $fatal(1, "conv_window_scheduler: illegal KERNEL/MAP/STRIDE/ADDR_WIDTH combination");
  end

  localparam logic [ADDR_WIDTH-1:0] L_OX_MAX = ADDR_WIDTH'(OX_MAX);
  localparam logic [ADDR_WIDTH-1:0] L_OY_MAX = ADDR_WIDTH'(OY_MAX);
  localparam logic [ADDR_WIDTH-1:0] L_STEP   = ADDR_WIDTH'(S_SAFE);
  localparam logic                  L_SINGLE = (OX_MAX == 0) && (OY_MAX == 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                       r_state;
  logic [ADDR_WIDTH-1:0]            r_ox;
  logic [ADDR_WIDTH-1:0]            r_oy;
  logic [ADDR_WIDTH-1:0]            r_idx;
  logic                             r_valid;
  logic                             r_last;
  logic                             r_busy;
  logic                             r_done;
  logic [PORT_NUM*ADDR_WIDTH-1:0]   r_winX;
  logic [PORT_NUM*ADDR_WIDTH-1:0]   r_winY;

  logic                             w_handshake;
  logic                             w_oyWrap;
  logic [ADDR_WIDTH-1:0]            w_nextOx;
  logic [ADDR_WIDTH-1:0]            w_nextOy;

  // x lanes step with the kernel row (kr), y lanes with the kernel column (kc)
  function automatic logic [PORT_NUM*ADDR_WIDTH-1:0] f_lanes(
    input logic [ADDR_WIDTH-1:0] base,
    input logic                  useRow
  );
    logic [PORT_NUM*ADDR_WIDTH-1:0] v;
    v = '0;
    for (int kr = 0; kr < KERNEL; kr++) begin
      for (int kc = 0; kc < KERNEL; kc++) begin
        v[(kr*KERNEL+kc)*ADDR_WIDTH +: ADDR_WIDTH] =
          base + ADDR_WIDTH'(useRow ? kr : kc);
      end
    end
    return v;
  endfunction

  assign w_handshake = r_valid & win_ready;
  assign w_oyWrap    = (r_oy == L_OY_MAX);
  assign w_nextOy    = w_oyWrap ? '0 : r_oy + L_STEP;
  assign w_nextOx    = w_oyWrap ? r_ox + L_STEP : r_ox;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ox    <= '0;
      r_oy    <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_winX  <= '0;
      r_winY  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_ox    <= '0;
            r_oy    <= '0;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_last  <= L_SINGLE;
            r_winX  <= f_lanes('0, 1'b1);
            r_winY  <= f_lanes('0, 1'b0);
          end
        end
        S_RUN: begin
          if (w_handshake) begin
            if (r_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_ox    <= w_nextOx;
              r_oy    <= w_nextOy;
              r_idx   <= r_idx + 1'b1;
              r_last  <= (w_nextOx == L_OX_MAX) && (w_nextOy == L_OY_MAX);
              r_winX  <= f_lanes(w_nextOx, 1'b1);
              r_winY  <= f_lanes(w_nextOy, 1'b0);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign win_valid = r_valid;
  assign win_last  = r_last;
  assign win_idx   = r_idx;
  assign win_x     = r_winX;
  assign win_y     = r_winY;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: three parameterisations share one stimulus
// engine, and every output is compared against a window-ordinal arithmetic model.
module tb_conv_window_scheduler;

  localparam int AW = 16;
  localparam int K  = 5;
  localparam int LW = K * K * AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic          ready;
  int            sel;
  logic [2:0]    startV;
  logic [2:0]    busyV, doneV, validV, lastV;
  logic [AW-1:0] idxV [3];
  logic [LW-1:0] wxV  [3];
  logic [LW-1:0] wyV  [3];

  int checks = 0;
  int errors = 0;
  int hsCount = 0;
  int doneCount = 0;

  // Model: frame state plus the ordinal of the window currently presented
  bit mValid, mBusy, mDone;
  int mN;

  int cfgS  [3] = '{1, 2, 1};
  int cfgMx [3] = '{25, 25, 5};
  int cfgMy [3] = '{30, 30, 5};

  always_comb begin
    startV = 3'b000;
    startV[sel] = start;
  end

  conv_window_scheduler u0 (
    .clk(clk), .rst_n(rst_n), .start(startV[0]), .busy(busyV[0]), .done(doneV[0]),
    .win_valid(validV[0]), .win_ready(ready), .win_last(lastV[0]),
    .win_idx(idxV[0]), .win_x(wxV[0]), .win_y(wyV[0]));

  conv_window_scheduler #(.STRIDE(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(startV[1]), .busy(busyV[1]), .done(doneV[1]),
    .win_valid(validV[1]), .win_ready(ready), .win_last(lastV[1]),
    .win_idx(idxV[1]), .win_x(wxV[1]), .win_y(wyV[1]));

  conv_window_scheduler #(.MAP_X(5), .MAP_Y(5)) u2 (
    .clk(clk), .rst_n(rst_n), .start(startV[2]), .busy(busyV[2]), .done(doneV[2]),
    .win_valid(validV[2]), .win_ready(ready), .win_last(lastV[2]),
    .win_idx(idxV[2]), .win_x(wxV[2]), .win_y(wyV[2]));

  function automatic int nxOf(int s);
    return (cfgMx[s] - K) / cfgS[s] + 1;
  endfunction

  function automatic int nyOf(int s);
    return (cfgMy[s] - K) / cfgS[s] + 1;
  endfunction

  function automatic int nwinOf(int s);
    return nxOf(s) * nyOf(s);
  endfunction

  // Window n has origin ox = (n / NY)*S, oy = (n % NY)*S; tap (kr,kc) = (ox+kr, oy+kc)
  function automatic logic [LW-1:0] expLanes(int s, int n, bit isX);
    logic [LW-1:0] v;
    int ox, oy;
    v  = '0;
    ox = (n / nyOf(s)) * cfgS[s];
    oy = (n % nyOf(s)) * cfgS[s];
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        v[(kr*K+kc)*AW +: AW] = AW'(isX ? ox + kr : oy + kc);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge, then drive the inputs for the next rising edge
  task automatic applyStimulus(input bit s, input bit r);
    logic [LW-1:0] wx, wy;
    bit nd;
    @(negedge clk);
    wx = wxV[sel];
    wy = wyV[sel];
    checkOutput("busy",  busyV[sel],  mBusy);
    checkOutput("done",  doneV[sel],  mDone);
    checkOutput("valid", validV[sel], mValid);
    if (mValid) begin
      checkOutput("idx",  idxV[sel], AW'(mN));
      checkOutput("last", lastV[sel], (mN == nwinOf(sel) - 1));
      checkOutput("winX", wx, expLanes(sel, mN, 1'b1));
      checkOutput("winY", wy, expLanes(sel, mN, 1'b0));
      if (mN == nwinOf(sel) - 1 && sel != 2) begin
        checkOutput("lastLane0x",  wx[AW-1:0], 20);
        checkOutput("lastLane0y",  wy[AW-1:0], (sel == 0) ? 25 : 24);
        checkOutput("lastLane24x", wx[24*AW +: AW], 24);
        checkOutput("lastLane24y", wy[24*AW +: AW], (sel == 0) ? 29 : 28);
      end
    end
    if (doneV[sel]) doneCount++;
    if (validV[sel] && r) hsCount++;
    start = s;
    ready = r;
    nd = 1'b0;
    if (mValid && r) begin
      if (mN == nwinOf(sel) - 1) begin
        mValid = 1'b0;
        mBusy  = 1'b0;
        nd     = 1'b1;
      end else begin
        mN++;
      end
    end else if (!mBusy && !mDone && s) begin
      mValid = 1'b1;
      mBusy  = 1'b1;
      mN     = 0;
    end
    mDone = nd;
  endtask

  task automatic runFrame(input int pct, input bit extraStarts);
    int hs0, d0, nw;
    bit fin, r, s;
    hs0 = hsCount;
    d0  = doneCount;
    nw  = nwinOf(sel);
    fin = 1'b0;
    applyStimulus(1'b1, 1'b0);
    for (int c = 0; c < 6000 && !fin; c++) begin
      r = ($urandom_range(99) < pct);
      s = extraStarts && mValid && ((mN == 100) || (mN == nw - 1 && r));
      applyStimulus(s, r);
      if (!mBusy && !mValid && !mDone) fin = 1'b1;
    end
    checkOutput("frameEnded", fin, 1'b1);
    checkOutput("windows", hsCount - hs0, nw);
    checkOutput("donePulses", doneCount - d0, 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},  busyV[sel],  0);
    checkOutput({tag, "_done"},  doneV[sel],  0);
    checkOutput({tag, "_valid"}, validV[sel], 0);
    checkOutput({tag, "_last"},  lastV[sel],  0);
    checkOutput({tag, "_idx"},   idxV[sel],   0);
    checkOutput({tag, "_winX"},  wxV[sel],    0);
    checkOutput({tag, "_winY"},  wyV[sel],    0);
  endtask

  task automatic abortMidFrame(input int at);
    int d0;
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0);
    for (int c = 0; c < 3000 && mValid && mN < at; c++)
      applyStimulus(1'b0, $urandom_range(1));
    checkOutput("reachedAbort", mN, at);
    #2 rst_n = 1'b0;
    #1 checkAllZero("async");
    mValid = 1'b0;
    mBusy  = 1'b0;
    mDone  = 1'b0;
    mN     = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("noDoneAfterAbort", doneCount - d0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    sel   = 0;
    mValid = 1'b0;
    mBusy  = 1'b0;
    mDone  = 1'b0;
    mN     = 0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    runFrame(100, 1'b0);
    runFrame(50, 1'b0);
    runFrame(100, 1'b1);
    runFrame(100, 1'b0);
    abortMidFrame(300);
    runFrame(100, 1'b0);

    sel = 1;
    runFrame(70, 1'b0);

    sel = 2;
    runFrame(100, 1'b0);
    runFrame(40, 1'b0);
    applyStimulus(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
